pattern_history: RTL and testbench
==================================

# pattern_history

Second-level branch predictor: a 32-entry table of 2-bit saturating counters, indexed by the PC index XOR the per-PC history word produced by the branch history table. It sits beside the history table in fetch and returns a taken/not-taken prediction in the lookup cycle. A small in-order queue remembers each prediction's table index until the branch resolves in the pipeline. At resolution the block trains the counter and flags a mispredict.

## Interface
Parameters:
- HIST_W, 5, width of PC index, history word and table index (matches lc3b_p_index; table has 2**HIST_W entries)
- DEPTH, 4, in-flight prediction queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- pc_index  in  HIST_W  index bits of the fetching branch's PC
- hist  in  HIST_W  history word for pc_index, read from the history table
- lookup  in  1  fetch requests a prediction this cycle
- lookup_ready  out  1  queue not full; a lookup is accepted only when high
- predict_taken  out  1  prediction for the current pc_index/hist, combinational
- resolve  in  1  oldest in-flight branch resolved this cycle
- resolve_taken  in  1  actual outcome of that branch
- flush  in  1  squash all in-flight predictions
- mispredict  out  1  registered; one-cycle pulse
- underflow  out  1  sticky; set when resolve arrives with the queue empty
- pending  out  $clog2(DEPTH)+1  number of in-flight entries
- stat_branches  out  16  resolved-branch count (see Configuration)
- stat_mispredicts  out  16  mispredict count (see Configuration)

## Operation
- Index: idx = pc_index ^ hist. predict_taken = ctr[idx][1].
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Reset: every counter = 01, queue empty, pending = 0, mispredict = 0, underflow = 0, stat counters = 0. lookup_ready = 1 after reset.
- Lookup accepted (lookup & lookup_ready & !flush): push {idx, predict_taken} at the tail and increment pending.
- Resolve with pending > 0: pop the head.
  - Taken: ctr[head.idx] increments and saturates at 11.
  - Not taken: ctr[head.idx] decrements and saturates at 00.
  - Next cycle, mispredict = (head.pred != resolve_taken).
- Resolve with pending = 0: no counter change, no pop, mispredict stays 0, underflow sets. underflow clears only on reset.
- Simultaneous accepted lookup and resolve: push and pop both occur, pending unchanged.
  - If the lookup idx equals the resolving idx, predict_taken uses the pre-update counter value.
- Full queue: lookup_ready = 0 and lookup is ignored, even if resolve pops in the same cycle. There is no same-cycle bypass.
- Flush: the resolve in the same cycle, if any, is processed first (counter update and mispredict). The queue then empties: pending = 0 and head = tail. A lookup in the same cycle is dropped. Counters are not touched for squashed entries.
- Head and tail pointers wrap modulo DEPTH. pending ranges 0..DEPTH.

## Timing
- predict_taken: zero latency, combinational from pc_index/hist and the counter array.
- Counter update from a resolve becomes visible to lookups on the following cycle.
- mispredict asserts exactly one cycle after the resolve cycle, for one cycle.
- lookup_ready and pending reflect state after the previous edge. Both are registered-derived, with no input-to-output path.
- A reset asserted mid-operation wins over every other input on that edge.

## Configuration
- PHT_STATS_EN defined:
  - stat_branches increments on every resolve with pending > 0.
  - stat_mispredicts increments on every such resolve that mispredicts.
  - Both saturate at 16'hFFFF and clear on reset.
- PHT_STATS_EN undefined: no counter logic exists, and both stat outputs are tied to 0.

## Test plan
- Reset, then lookup with pc_index = 5'h03 and hist = 5'h00 -> predict_taken = 0, pending = 1, lookup_ready = 1.
- Index 5'h03 trained with three lookup/resolve_taken = 1 pairs:
  - Counter goes 01 -> 10 -> 11 -> 11.
  - The first resolve gives mispredict = 1 one cycle later; the 2nd and 3rd give 0.
  - The next lookup of idx 3 predicts taken.
- DEPTH lookups with no resolve -> pending = 4, lookup_ready = 0. A 5th lookup is ignored. A simultaneous resolve + lookup when full leaves pending = 3.
- Resolve with queue empty -> underflow = 1 and stays 1, counters unchanged, mispredict = 0.
- Three pending entries, then flush together with resolve_taken = 1 -> only the head counter trains, pending = 0, later resolves raise underflow.
- With PHT_STATS_EN: 4 resolves, 1 of them mispredicted -> stat_branches = 4, stat_mispredicts = 1. Without the macro, both read 0.

Source files
------------

// File: rtl/pattern_history.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_history
//  Description : Second-level branch predictor. 2**HIST_W two-bit saturating
//                counters indexed by pc_index ^ hist. The prediction is
//                combinational. An in-order queue holds {idx, pred} for each
//                in-flight branch until it resolves or is flushed.
//                Optional statistics counters are built when the macro
//                PHT_STATS_EN is defined. Otherwise the stat outputs are tied
//                to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_history #(
    parameter int HIST_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [HIST_W-1:0]      pc_index,
    input  logic [HIST_W-1:0]      hist,
    input  logic                   lookup,
    output logic                   lookup_ready,
    output logic                   predict_taken,
    input  logic                   resolve,
    input  logic                   resolve_taken,
    input  logic                   flush,
    output logic                   mispredict,
    output logic                   underflow,
    output logic [$clog2(DEPTH):0] pending,
    output logic [15:0]            stat_branches,
    output logic [15:0]            stat_mispredicts
);

    localparam int                 c_ENTRIES = 2 ** HIST_W;
    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);

    // Counter table and in-flight queue storage
    logic [1:0]          r_ctr    [c_ENTRIES];
    logic [HIST_W-1:0]   r_q_idx  [DEPTH];
    logic                r_q_pred [DEPTH];
    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_mispredict;
    logic                r_underflow;

    logic [HIST_W-1:0]   w_idx;
    logic                w_push;
    logic                w_pop;
    logic [HIST_W-1:0]   w_head_idx;
    logic                w_head_pred;
    logic [1:0]          w_head_ctr;
    logic [1:0]          w_ctr_next;

    assign w_idx         = pc_index ^ hist;
    assign predict_taken = r_ctr[w_idx][1];

    // Readiness is derived from registered occupancy only. A pop in the same
    // cycle does not free a slot for a lookup.
    assign lookup_ready  = (r_count != c_FULL);
    assign pending       = r_count;
    assign mispredict    = r_mispredict;
    assign underflow     = r_underflow;

    // A flush drops the lookup in the same cycle. A resolve is still
    // honoured in that cycle.
    assign w_push      = lookup & lookup_ready & ~flush;
    assign w_pop       = resolve & (r_count != '0);
    assign w_head_idx  = r_q_idx[r_head];
    assign w_head_pred = r_q_pred[r_head];
    assign w_head_ctr  = r_ctr[w_head_idx];

    // Saturating increment on taken, saturating decrement on not-taken
    always_comb begin
        w_ctr_next = w_head_ctr;
        if (resolve_taken) begin
            if (w_head_ctr != 2'b11) begin
                w_ctr_next = w_head_ctr + 2'b01;
            end
        end else begin
            if (w_head_ctr != 2'b00) begin
                w_ctr_next = w_head_ctr - 2'b01;
            end
        end
    end

    // Counter table: all counters start weakly not-taken, and a resolving
    // branch trains its own entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else if (w_pop) begin
            r_ctr[w_head_idx] <= w_ctr_next;
        end
    end

    // Queue payload. No reset is needed because only occupied slots are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_idx[r_tail]  <= w_idx;
            r_q_pred[r_tail] <= predict_taken;
        end
    end

    // Queue pointers and occupancy. A flush collapses the head onto the tail.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Mispredict is a one-cycle pulse. Underflow is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mispredict <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_mispredict <= w_pop & (w_head_pred != resolve_taken);
            if (resolve && (r_count == '0)) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef PHT_STATS_EN
    logic [15:0] r_stat_br;
    logic [15:0] r_stat_mp;

    // Saturating resolved-branch and mispredict counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else if (w_pop) begin
            if (r_stat_br != 16'hFFFF) begin
                r_stat_br <= r_stat_br + 16'd1;
            end
            if ((w_head_pred != resolve_taken) && (r_stat_mp != 16'hFFFF)) begin
                r_stat_mp <= r_stat_mp + 16'd1;
            end
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mp;
`else
    assign stat_branches    = 16'd0;
    assign stat_mispredicts = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pattern_history.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_history
//  Description : Self-checking bench for pattern_history. A queue-based
//                reference model runs alongside the DUT and is checked on
//                every negedge. Directed literal checks pin the model, and
//                randomized traffic follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_history;

    localparam int HIST_W = 5;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  pc_index = '0;
    logic [4:0]  hist = '0;
    logic        lookup = 1'b0;
    logic        resolve = 1'b0;
    logic        resolve_taken = 1'b0;
    logic        flush = 1'b0;
    logic        lookup_ready;
    logic        predict_taken;
    logic        mispredict;
    logic        underflow;
    logic [2:0]  pending;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;

    int n_vec  = 0;
    int n_fail = 0;

    pattern_history #(.HIST_W(HIST_W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_index         (pc_index),
        .hist             (hist),
        .lookup           (lookup),
        .lookup_ready     (lookup_ready),
        .predict_taken    (predict_taken),
        .resolve          (resolve),
        .resolve_taken    (resolve_taken),
        .flush            (flush),
        .mispredict       (mispredict),
        .underflow        (underflow),
        .pending          (pending),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int idx;
        bit pred;
    } ent_t;

    int   m_ctr [32];
    ent_t m_q [$];
    bit   m_valid = 0;
    bit   m_misp = 0;
    bit   m_under = 0;
    int   m_br = 0;
    int   m_mp = 0;
    bit   m_pop_ok;
    bit   m_push_ok;
    ent_t m_new;
    ent_t m_head;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_ctr[i] = 1;
            m_q.delete();
            m_misp  = 0;
            m_under = 0;
            m_br    = 0;
            m_mp    = 0;
            m_valid = 1;
        end else begin
            m_pop_ok   = resolve && (m_q.size() > 0);
            m_push_ok  = lookup && (m_q.size() < DEPTH) && !flush;
            m_new.idx  = int'(pc_index ^ hist);
            m_new.pred = (m_ctr[m_new.idx] >= 2);
            m_misp     = 0;
            if (resolve && m_q.size() == 0) m_under = 1;
            if (m_pop_ok) begin
                m_head = m_q.pop_front();
                if (resolve_taken) m_ctr[m_head.idx] = (m_ctr[m_head.idx] == 3) ? 3 : m_ctr[m_head.idx] + 1;
                else               m_ctr[m_head.idx] = (m_ctr[m_head.idx] == 0) ? 0 : m_ctr[m_head.idx] - 1;
                m_misp = (m_head.pred != resolve_taken);
                if (m_br < 16'hFFFF) m_br++;
                if (m_misp && m_mp < 16'hFFFF) m_mp++;
            end
            if (flush) m_q.delete();
            else if (m_push_ok) m_q.push_back(m_new);
        end
    end

    // Compare process: every negedge once the model has seen a reset
    always @(negedge clk) begin
        if (m_valid) begin
            check("predict_taken", predict_taken, (m_ctr[int'(pc_index ^ hist)] >= 2));
            check("lookup_ready", lookup_ready, (m_q.size() < DEPTH));
            check("pending", pending, m_q.size());
            check("mispredict", mispredict, m_misp);
            check("underflow", underflow, m_under);
`ifdef PHT_STATS_EN
            check("stat_branches", stat_branches, m_br);
            check("stat_mispredicts", stat_mispredicts, m_mp);
`else
            check("stat_branches", stat_branches, 0);
            check("stat_mispredicts", stat_mispredicts, 0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit lk, input int pc, input int h, input bit rs, input bit rt, input bit fl);
        lookup        = lk;
        pc_index      = 5'(pc);
        hist          = 5'(h);
        resolve       = rs;
        resolve_taken = rt;
        flush         = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_pending", pending, 0);
        check("rst_ready", lookup_ready, 1);
        check("rst_underflow", underflow, 0);
        check("rst_mispredict", mispredict, 0);

        // Train index 3 with three lookup/taken pairs
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 0, 0, 0, 0);
            #1;
            check("train_pred", predict_taken, (i == 0) ? 0 : 1);
            tick();
            if (i == 0) begin
                check("first_pending", pending, 1);
                check("first_ready", lookup_ready, 1);
            end
            drive(0, 0, 0, 1, 1, 0);
            tick();
            check("train_misp", mispredict, (i == 0) ? 1 : 0);
        end
        drive(0, 5'h01, 5'h02, 0, 0, 0);
        #1;
        check("trained_pred", predict_taken, 1);
        tick();

        // Fill the queue, then try to over-fill it
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 7, 0, 0, 0, 0);
            tick();
        end
        check("full_pending", pending, 4);
        check("full_ready", lookup_ready, 0);
        drive(1, 7, 0, 0, 0, 0);
        tick();
        check("full_ignore", pending, 4);
        drive(1, 7, 0, 1, 0, 0);
        tick();
        check("full_pop_push", pending, 3);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            tick();
        end
        check("drained", pending, 0);

        // Resolve with an empty queue
        drive(0, 3, 0, 1, 0, 0);
        tick();
        check("under_set", underflow, 1);
        check("under_misp", mispredict, 0);
        drive(0, 3, 0, 0, 0, 0);
        tick();
        check("under_sticky", underflow, 1);
        check("under_ctr", predict_taken, 1);

        // Flush with a same-cycle resolve
        do_reset();
        for (int i = 9; i < 12; i++) begin
            drive(1, i, 0, 0, 0, 0);
            tick();
        end
        check("pre_flush_pending", pending, 3);
        drive(0, 0, 0, 1, 1, 1);
        tick();
        check("flush_pending", pending, 0);
        check("flush_misp", mispredict, 1);
        drive(0, 9, 0, 0, 0, 0);
        #1;
        check("flush_head_trained", predict_taken, 1);
        drive(0, 10, 0, 0, 0, 0);
        #1;
        check("flush_sq1_untouched", predict_taken, 0);
        drive(0, 11, 0, 0, 0, 0);
        #1;
        check("flush_sq2_untouched", predict_taken, 0);
        drive(0, 0, 0, 1, 0, 0);
        tick();
        check("flush_underflow", underflow, 1);

        // Statistics: four resolves, the last one mispredicted
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 20, 0, 0, 0, 0);
            tick();
            drive(0, 20, 0, 1, (i == 3), 0);
            tick();
        end
`ifdef PHT_STATS_EN
        check("stat_br_lit", stat_branches, 4);
        check("stat_mp_lit", stat_mispredicts, 1);
`else
        check("stat_br_lit", stat_branches, 0);
        check("stat_mp_lit", stat_mispredicts, 0);
`endif

        // Randomized traffic over a small index space to force aliasing
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 99) < 60,
                  $urandom_range(0, 7),
                  $urandom_range(0, 3),
                  $urandom_range(0, 99) < 45,
                  $urandom_range(0, 1),
                  $urandom_range(0, 31) == 0);
            tick();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
